// File: rtl/router_pkg.sv
// router_pkg: shared types and constants for the packet generator and router
package router_pkg;
   localparam int BYTE_W      = 8;
   localparam int MAX_PAYLOAD = 7;
   localparam int SIZE_W      = $clog2(MAX_PAYLOAD + 1);
   typedef enum logic [2:0] {IDLE, HDR, SRC, DATA, PAR} state_t;
endpackage

// File: rtl/transmitter.sv
// transmitter: byte-serial packet generator (header, source id, payload, parity)
// Ports:
//   clk, rst (async, active-low)
//   srcid, dstid, actual_size : packet fields, sampled when a packet starts
//   start_packet_gen          : level enable for back-to-back packets
//   stop_packet               : level pause; blanks the stream and freezes progress
//   packet_gen_output/_valid  : packet byte and its qualifier (00 when not valid)
//   packet_starting/_ending   : strobes on header byte and parity byte
module transmitter
   import router_pkg::*;
#(
   parameter logic [BYTE_W-1:0] DATA_INIT = 8'h00
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [BYTE_W-1:0] srcid,
   input  logic [BYTE_W-1:0] dstid,
   input  logic [SIZE_W-1:0] actual_size,
   input  logic              start_packet_gen,
   input  logic              stop_packet,
   output logic [BYTE_W-1:0] packet_gen_output,
   output logic              packet_gen_valid,
   output logic              packet_starting,
   output logic              packet_ending
);
   state_t            r_state, w_state;
   logic [BYTE_W-1:0] r_dst, w_dst, r_src, w_src, r_par, w_par, w_byte;
   logic [SIZE_W-1:0] r_size, w_size, r_idx, w_idx;
   logic              r_stall, w_stall;

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_state <= IDLE;
         r_dst   <= '0;
         r_src   <= '0;
         r_size  <= '0;
         r_idx   <= '0;
         r_par   <= '0;
         r_stall <= 1'b0;
      end else begin
         r_state <= w_state;
         r_dst   <= w_dst;
         r_src   <= w_src;
         r_size  <= w_size;
         r_idx   <= w_idx;
         r_par   <= w_par;
         r_stall <= w_stall;
      end

   // byte owned by the current state, whether or not it is shown this cycle
   assign w_byte = (r_state == HDR)  ? r_dst :
                   (r_state == SRC)  ? r_src :
                   (r_state == DATA) ? DATA_INIT + BYTE_W'(r_idx) :
                   (r_state == PAR)  ? r_par : '0;

   always_comb begin
      w_state = r_state;
      w_dst   = r_dst;
      w_src   = r_src;
      w_size  = r_size;
      w_idx   = r_idx;
      w_par   = r_par;
      w_stall = 1'b0;
      if (r_state == IDLE) begin
         if (start_packet_gen && !stop_packet) begin
            w_state = HDR;
            w_dst   = dstid;
            w_src   = srcid;
            w_size  = actual_size;
            w_idx   = '0;
            w_par   = '0;
         end
      end else if (stop_packet) begin
         w_stall = 1'b1;
      end else begin
         // the byte just emitted joins the parity as we move past it
         w_par = r_par ^ w_byte;
         case (r_state)
            HDR:     w_state = SRC;
            SRC:     w_state = (r_size != '0) ? DATA : PAR;
            DATA: begin
               w_idx   = r_idx + SIZE_W'(1);
               w_state = (w_idx == r_size) ? PAR : DATA;
            end
            default: w_state = IDLE;
         endcase
      end
   end

   assign packet_gen_valid  = (r_state != IDLE) && !r_stall;
   assign packet_gen_output = packet_gen_valid ? w_byte : '0;
   assign packet_starting   = packet_gen_valid && (r_state == HDR);
   assign packet_ending     = packet_gen_valid && (r_state == PAR);
endmodule

// File: tb/tb_transmitter.sv
// tb_transmitter: randomized self-checking bench for the packet generator
module tb_transmitter;
   localparam logic [7:0] DATA_INIT = 8'h00;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] srcid, dstid;
   logic [2:0] actual_size;
   logic       start_packet_gen, stop_packet;
   logic [7:0] packet_gen_output;
   logic       packet_gen_valid, packet_starting, packet_ending;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   transmitter #(.DATA_INIT(DATA_INIT)) dut (
      .clk(clk),
      .rst(rst),
      .srcid(srcid),
      .dstid(dstid),
      .actual_size(actual_size),
      .start_packet_gen(start_packet_gen),
      .stop_packet(stop_packet),
      .packet_gen_output(packet_gen_output),
      .packet_gen_valid(packet_gen_valid),
      .packet_starting(packet_starting),
      .packet_ending(packet_ending)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Drives the fields at the current negedge (start already high), then follows
   // the whole packet against a list built from the packet format rules.
   task automatic check_pkt(input string name, input logic [7:0] d, input logic [7:0] s,
                            input int n, input int stall_at, input int stall_len);
      logic [7:0] q[$];
      logic [7:0] p;
      int t, c0, c1, exp_span;
      q = {d, s};
      for (int k = 0; k < n; k++) q.push_back(DATA_INIT + 8'(k));
      p = '0;
      foreach (q[k]) p ^= q[k];
      q.push_back(p);
      dstid = d;
      srcid = s;
      actual_size = 3'(n);
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!packet_gen_valid && t < 8);
      checks++;
      if (t != 1 || !packet_gen_valid) begin
         failures++;
         $display("FAIL %s start_latency got=%0d cycles valid=%b required=1 cycle", name, t, packet_gen_valid);
         if (!packet_gen_valid) return;
      end
      c0 = cyc;
      c1 = cyc;
      for (int i = 0; i < q.size(); i++) begin
         t = 0;
         while (!packet_gen_valid && t < 10) begin
            @(negedge clk);
            t++;
         end
         checks++;
         if (!packet_gen_valid || packet_gen_output !== q[i] || packet_starting !== (i == 0) ||
             packet_ending !== (i == q.size() - 1)) begin
            failures++;
            $display("FAIL %s byte%0d got=%h v=%b sop=%b eop=%b required=%h sop=%b eop=%b", name, i,
                     packet_gen_output, packet_gen_valid, packet_starting, packet_ending, q[i],
                     i == 0, i == q.size() - 1);
         end
         c1 = cyc;
         if (i == stall_at) begin
            stop_packet = 1'b1;
            for (int j = 0; j < stall_len; j++) begin
               @(negedge clk);
               checks++;
               if (packet_gen_valid !== 1'b0 || packet_gen_output !== 8'h00 || packet_starting !== 1'b0 ||
                   packet_ending !== 1'b0) begin
                  failures++;
                  $display("FAIL %s stall%0d got out=%h v=%b sop=%b eop=%b required all 0", name, j,
                           packet_gen_output, packet_gen_valid, packet_starting, packet_ending);
               end
            end
            stop_packet = 1'b0;
         end else begin
            @(negedge clk);
         end
      end
      exp_span = q.size() - 1 + ((stall_at >= 0 && stall_at < q.size()) ? stall_len : 0);
      checks++;
      if (c1 - c0 != exp_span || packet_gen_valid !== 1'b0) begin
         failures++;
         $display("FAIL %s span got=%0d idle_valid=%b required span=%0d idle_valid=0", name, c1 - c0,
                  packet_gen_valid, exp_span);
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      start_packet_gen = 1'b0;
      stop_packet = 1'b0;
      srcid = 8'h00;
      dstid = 8'h00;
      actual_size = 3'd0;
      repeat (10) @(negedge clk);
      checks++;
      if ({packet_gen_output, packet_gen_valid, packet_starting, packet_ending} !== 11'd0) begin
         failures++;
         $display("FAIL reset_outputs got out=%h v=%b sop=%b eop=%b required all 0", packet_gen_output,
                  packet_gen_valid, packet_starting, packet_ending);
      end
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (packet_gen_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_start cycle%0d got valid=%b required 0", i, packet_gen_valid);
         end
      end
   endtask

   task automatic test_basic;
      start_packet_gen = 1'b1;
      check_pkt("basic_sz4", 8'hF8, 8'h05, 4, -1, 0);
   endtask

   task automatic test_stop_idle;
      stop_packet = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (packet_gen_valid !== 1'b0) begin
            failures++;
            $display("FAIL stop_idle cycle%0d got valid=%b required 0", i, packet_gen_valid);
         end
      end
      stop_packet = 1'b0;
      check_pkt("after_stop_sz5", 8'h08, 8'h06, 5, -1, 0);
   endtask

   task automatic test_back_to_back;
      check_pkt("b2b_sz7", 8'h45, 8'h06, 7, -1, 0);
      check_pkt("b2b_sz0", 8'h0F, 8'h07, 0, -1, 0);
   endtask

   task automatic test_stall;
      check_pkt("stall_data", 8'hF8, 8'h05, 4, 3, 2);
      check_pkt("stall_hdr", 8'h12, 8'h34, 2, 0, 3);
   endtask

   task automatic test_start_drop;
      fork
         check_pkt("start_drop", 8'hA5, 8'h5A, 3, -1, 0);
         begin
            repeat (2) @(negedge clk);
            start_packet_gen = 1'b0;
         end
      join
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (packet_gen_valid !== 1'b0) begin
            failures++;
            $display("FAIL start_drop_idle cycle%0d got valid=%b required 0", i, packet_gen_valid);
         end
      end
   endtask

   task automatic test_reset_mid;
      int t;
      dstid = 8'hF8;
      srcid = 8'h05;
      actual_size = 3'd4;
      start_packet_gen = 1'b1;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!packet_starting && t < 8);
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({packet_gen_output, packet_gen_valid, packet_starting, packet_ending} !== 11'd0) begin
         failures++;
         $display("FAIL reset_mid got out=%h v=%b sop=%b eop=%b required all 0", packet_gen_output,
                  packet_gen_valid, packet_starting, packet_ending);
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      check_pkt("after_reset", 8'h3C, 8'h11, 2, -1, 0);
   endtask

   task automatic test_random;
      int n, sa, sl;
      start_packet_gen = 1'b1;
      for (int r = 0; r < 20; r++) begin
         n = $urandom_range(0, 7);
         sa = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, n + 1);
         sl = $urandom_range(1, 3);
         check_pkt($sformatf("rand%0d", r), 8'($urandom), 8'($urandom), n, sa, sl);
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_stop_idle;
      test_back_to_back;
      test_stall;
      test_start_drop;
      test_reset_mid;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
